// File: rtl/freq_meter_pkg.sv
// rtl/freq_meter_pkg.sv - shared constants, controller state type and result byte selector
`timescale 1ns/1ps
package freq_meter_pkg;

    localparam int NUM_CH = 5;
    localparam int CNT_W  = 32;
    localparam int RES_W  = 2 * CNT_W;

    localparam logic [7:0] CMD_DATA_RD = 8'h3B;

    typedef enum logic {
        IDLE = 1'b0,
        READ = 1'b1
    } ctrl_state_t;

    // Byte idx of a result word, idx 0 = most significant byte.
    function automatic logic [7:0] result_byte(input logic [RES_W-1:0] data,
                                               input logic [2:0]       idx);
        logic [RES_W-1:0] shifted;
        shifted = data << (8 * idx);
        return shifted[RES_W-1 -: 8];
    endfunction

endpackage

// File: rtl/freq_meter_channel.sv
// rtl/freq_meter_channel.sv - one gated measurement channel (edge-aligned gate, signal/reference counters)
//
// Ports:
//   clk_i, rst_n_i   reference clock, synchronous active-low reset
//   sig_rise_i       one-cycle pulse per conditioned signal rising edge
//   gate_en_i        gate request from the startup sequencer
//   gate_sync_o      gate aligned to signal edges
//   wr_en_o          one-cycle strobe in the cycle the aligned gate falls
//   wr_data_o        {sig_cnt, ref_cnt}, valid with wr_en_o
`timescale 1ns/1ps
module freq_meter_channel
    import freq_meter_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             sig_rise_i,
    input  logic             gate_en_i,
    output logic             gate_sync_o,
    output logic             wr_en_o,
    output logic [RES_W-1:0] wr_data_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             gate_q;
    logic             gate_d;
    logic [CNT_W-1:0] sig_cnt;
    logic [CNT_W-1:0] ref_cnt;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            gate_q  <= 1'b0;
            gate_d  <= 1'b0;
            sig_cnt <= '0;
            ref_cnt <= '0;
        end else begin
            gate_d <= gate_q;
            // Gate only changes on a signal edge, so the window spans whole signal periods.
            if (sig_rise_i) begin
                gate_q <= gate_en_i;
            end
            if (wr_en_o) begin
                sig_cnt <= '0;
                ref_cnt <= '0;
            end else begin
                // An edge seen with the request high is counted, including the opening edge;
                // the closing edge (request low) is not.
                if (sig_rise_i && gate_en_i && (sig_cnt != CNT_MAX)) begin
                    sig_cnt <= sig_cnt + 1'b1;
                end
                if (gate_q && (ref_cnt != CNT_MAX)) begin
                    ref_cnt <= ref_cnt + 1'b1;
                end
            end
        end
    end

    assign gate_sync_o = gate_q;
    assign wr_en_o     = gate_d & ~gate_q;
    assign wr_data_o   = {sig_cnt, ref_cnt};

endmodule

// File: rtl/freq_meter_core.sv
// rtl/freq_meter_core.sv - reciprocal frequency-meter core: channels, result merge, command decoder, read regfile
//
// Ports:
//   clk_i, rst_n_i       reference clock, synchronous active-low reset
//   dc_i                 0 = command byte, 1 = data byte
//   spi_byte_vld_i       one-cycle strobe, byte received
//   spi_byte_data_i      received byte
//   sig_clk_i            measured signal, asynchronous
//   gate_en_i            per-channel gate request
//   gate_sync_o          per-channel gate aligned to signal edges
//   reg_rd_data_o        selected result byte
// Build option: FREQ_METER_SYNC2_EN selects a 2-flop synchronizer on sig_clk_i
// (default: a single register stage).
`timescale 1ns/1ps
module freq_meter_core
    import freq_meter_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              dc_i,
    input  logic              spi_byte_vld_i,
    input  logic [7:0]        spi_byte_data_i,
    input  logic              sig_clk_i,
    input  logic [NUM_CH-1:0] gate_en_i,
    output logic [NUM_CH-1:0] gate_sync_o,
    output logic [7:0]        reg_rd_data_o
);

    // ---------------- signal conditioning ----------------
    logic sig_s;
    logic sig_s_d;
    logic sig_rise;

`ifdef FREQ_METER_SYNC2_EN
    logic sig_meta;
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            sig_meta <= 1'b0;
            sig_s    <= 1'b0;
        end else begin
            sig_meta <= sig_clk_i;
            sig_s    <= sig_meta;
        end
    end
`else
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            sig_s <= 1'b0;
        end else begin
            sig_s <= sig_clk_i;
        end
    end
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            sig_s_d  <= 1'b0;
            sig_rise <= 1'b0;
        end else begin
            sig_s_d  <= sig_s;
            sig_rise <= sig_s & ~sig_s_d;
        end
    end

    // ---------------- channels ----------------
    logic [NUM_CH-1:0] ch_wr_en;
    logic [RES_W-1:0]  ch_wr_data [NUM_CH];

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        freq_meter_channel u_ch (
            .clk_i       (clk_i),
            .rst_n_i     (rst_n_i),
            .sig_rise_i  (sig_rise),
            .gate_en_i   (gate_en_i[g]),
            .gate_sync_o (gate_sync_o[g]),
            .wr_en_o     (ch_wr_en[g]),
            .wr_data_o   (ch_wr_data[g])
        );
    end

    // ---------------- write merge ----------------
    logic [RES_W-1:0] sel_data;
    logic             wr_en_q;
    logic [RES_W-1:0] wr_data_q;
    logic [RES_W-1:0] result;

    // Descending scan so the lowest-index writer is the last (winning) assignment.
    always_comb begin
        sel_data = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (ch_wr_en[i]) begin
                sel_data = ch_wr_data[i];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            wr_en_q   <= 1'b0;
            wr_data_q <= '0;
            result    <= '0;
        end else begin
            wr_en_q   <= |ch_wr_en;
            wr_data_q <= sel_data;
            if (wr_en_q) begin
                result <= wr_data_q;
            end
        end
    end

    // ---------------- command decoder ----------------
    ctrl_state_t state;
    logic        rd_en;
    logic [2:0]  addr;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state <= IDLE;
            rd_en <= 1'b0;
            addr  <= '0;
        end else begin
            rd_en <= 1'b0;
            if (spi_byte_vld_i) begin
                if (!dc_i) begin
                    // Any command byte is decoded afresh, whatever the current state.
                    if (spi_byte_data_i == CMD_DATA_RD) begin
                        state <= READ;
                        rd_en <= 1'b1;
                        addr  <= '0;
                    end else begin
                        state <= IDLE;
                    end
                end else if (state == READ) begin
                    addr  <= addr + 1'b1;
                    rd_en <= 1'b1;
                end
            end
        end
    end

    // ---------------- read regfile ----------------
    logic             rd_en_q;
    logic [2:0]       addr_q;
    logic [RES_W-1:0] snapshot;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            rd_en_q       <= 1'b0;
            addr_q        <= '0;
            snapshot      <= '0;
            reg_rd_data_o <= '0;
        end else begin
            rd_en_q <= rd_en;
            addr_q  <= addr;
            if (rd_en_q) begin
                // Byte 0 freezes the word so a result landing mid-read cannot tear it.
                if (addr_q == 3'd0) begin
                    snapshot      <= result;
                    reg_rd_data_o <= result_byte(result, 3'd0);
                end else begin
                    reg_rd_data_o <= result_byte(snapshot, addr_q);
                end
            end
        end
    end

endmodule

// File: tb/tb_freq_meter_core.sv
// tb/tb_freq_meter_core.sv - scoreboard bench for freq_meter_core
`timescale 1ns/1ps
module tb_freq_meter_core;
    import freq_meter_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              dc = 1'b0;
    logic              vld = 1'b0;
    logic [7:0]        byte_data = 8'h00;
    logic              sig = 1'b0;
    logic [NUM_CH-1:0] gate_en = '0;
    logic [NUM_CH-1:0] gate_sync;
    logic [7:0]        rd_data;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    logic [2:0] hist = 3'b000;
    logic       g0_prev = 1'b0;
    int         fall_cnt0 = 0;

    // Hand-computed results: 4.8 ns clock, 500 ns signal period, first edge 1 ns after a clock edge.
    localparam logic [63:0] RES_MEAS = 64'h00000014_00000823;  // 20 edges, 2083 cycles
    localparam logic [63:0] RES_COLL = 64'h00000005_00000209;  // channel 1: 5 edges, 521 cycles
    localparam logic [63:0] RES_NEW  = 64'h00000002_000000D0;  // channel 2: 2 edges, 208 cycles

    freq_meter_core dut (
        .clk_i           (clk),
        .rst_n_i         (rst_n),
        .dc_i            (dc),
        .spi_byte_vld_i  (vld),
        .spi_byte_data_i (byte_data),
        .sig_clk_i       (sig),
        .gate_en_i       (gate_en),
        .gate_sync_o     (gate_sync),
        .reg_rd_data_o   (rd_data)
    );

    always #2.4 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] byte_of(input logic [63:0] v, input int idx);
        logic [63:0] t;
        t = v >> (56 - 8 * idx);
        return t[7:0];
    endfunction

    task automatic send_byte(input logic is_data, input logic [7:0] b, input logic [7:0] exp);
        exp_q.push_back(exp);
        @(posedge clk); #1;
        dc = is_data;
        byte_data = b;
        vld = 1'b1;
        @(posedge clk); #1;
        vld = 1'b0;
        repeat (4) @(posedge clk);
    endtask

    task automatic read_word(input logic [63:0] v, input int ndata);
        send_byte(1'b0, CMD_DATA_RD, byte_of(v, 0));
        for (int k = 1; k <= ndata; k++) begin
            send_byte(1'b1, 8'hA5, byte_of(v, k % 8));
        end
    endtask

    task automatic sig_pulses(input int n);
        for (int j = 0; j < n; j++) begin
            sig = 1'b1; #250;
            sig = 1'b0; #250;
        end
    endtask

    // Monitor: the output byte for a strobe sampled at edge k is presented after edge k+2.
    initial begin
        logic [7:0] e;
        forever begin
            @(posedge clk);
            hist = {hist[1:0], vld};
            @(negedge clk);
            if (hist[2]) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL read_byte: got %0h with no expected byte queued", rd_data);
                end else begin
                    e = exp_q.pop_front();
                    check("read_byte", 64'(rd_data), 64'(e));
                end
            end
        end
    end

    always @(negedge clk) begin
        if (g0_prev && !gate_sync[0]) fall_cnt0++;
        g0_prev = gate_sync[0];
    end

    initial begin
        // Reset
        repeat (5) @(posedge clk); #1;
        check("reset_gate_sync", 64'(gate_sync), 64'd0);
        check("reset_rd_data", 64'(rd_data), 64'd0);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        read_word(64'd0, 7);

        // Single measurement on channel 0
        @(posedge clk); #1;
        gate_en[0] = 1'b1;
        sig_pulses(10);
        check("gate0_open", 64'(gate_sync[0]), 64'd1);
        sig_pulses(10);
        gate_en[0] = 1'b0;
        sig_pulses(1);
        repeat (10) @(posedge clk); #1;
        check("gate0_closed", 64'(gate_sync), 64'd0);
        check("gate0_fall_count", 64'(fall_cnt0), 64'd1);
        read_word(RES_MEAS, 7);

        // Unknown command then data bytes: output holds the last byte
        send_byte(1'b0, 8'h3A, byte_of(RES_MEAS, 7));
        send_byte(1'b1, 8'h11, byte_of(RES_MEAS, 7));
        send_byte(1'b1, 8'h22, byte_of(RES_MEAS, 7));

        // Channels 1 and 3 close on the same edge; channel 1 wins
        @(posedge clk); #1;
        gate_en[3] = 1'b1;
        sig_pulses(3);
        gate_en[1] = 1'b1;
        sig_pulses(5);
        gate_en[1] = 1'b0;
        gate_en[3] = 1'b0;
        sig_pulses(1);
        repeat (10) @(posedge clk);
        read_word(RES_COLL, 8);  // last data byte wraps to byte 0

        // New result arrives mid-read
        read_word(RES_COLL, 3);
        @(posedge clk); #1;
        gate_en[2] = 1'b1;
        sig_pulses(2);
        gate_en[2] = 1'b0;
        sig_pulses(1);
        repeat (10) @(posedge clk);
        for (int k = 4; k < 8; k++) begin
            send_byte(1'b1, 8'h5A, byte_of(RES_COLL, k));
        end
        read_word(RES_NEW, 7);

        repeat (20) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected bytes never presented, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
